// File: rtl/cache_refill_engine.sv
// cache_refill_engine: fetches one missed cache line as a single 8-beat burst,
// assembles the 32-bit beats into a 256-bit line and writes it into the data
// array in one cycle. An early 'last' aborts the refill without a write; a
// missing 'last' on the final beat writes the line but flags an error.
module cache_refill_engine #(
    parameter int LINE_WIDTH     = 256,
    parameter int BEAT_WIDTH     = 32,
    parameter int SET_ADDR_WIDTH = 3,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      resetn,
    // cache control FSM side
    input  logic                      refill_valid,
    input  logic [ADDR_WIDTH-1:0]     refill_addr,
    output logic                      refill_ready,
    output logic                      refill_done,
    output logic                      refill_err,
    // memory read request channel
    output logic                      mem_rd_req_valid,
    output logic [ADDR_WIDTH-1:0]     mem_rd_req_addr,
    output logic [7:0]                mem_rd_req_len,
    input  logic                      mem_rd_req_ready,
    // memory read response channel
    input  logic                      mem_rd_rsp_valid,
    input  logic [BEAT_WIDTH-1:0]     mem_rd_rsp_data,
    input  logic                      mem_rd_rsp_last,
    output logic                      mem_rd_rsp_ready,
    // data-array write port
    output logic                      arr_wen,
    output logic [SET_ADDR_WIDTH-1:0] arr_waddr,
    output logic [LINE_WIDTH-1:0]     arr_wdata
);

    localparam int BEATS        = LINE_WIDTH / BEAT_WIDTH;
    localparam int CNT_WIDTH    = $clog2(BEATS);
    localparam int OFFSET_WIDTH = $clog2(LINE_WIDTH / 8);
    localparam int TAG_WIDTH    = ADDR_WIDTH - OFFSET_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RECV,
        WRITE
    } state_t;

    state_t                 state;
    // Only the line-aligned part of the request address is kept; the byte
    // offset inside the line is irrelevant to a whole-line refill.
    logic [TAG_WIDTH-1:0]   line_addr;
    logic [CNT_WIDTH-1:0]   beat_cnt;
    logic [LINE_WIDTH-1:0]  line_buf;
    logic                   sticky_err;

    assign mem_rd_req_addr = {line_addr, {OFFSET_WIDTH{1'b0}}};
    assign mem_rd_req_len  = 8'(BEATS - 1);
    assign arr_waddr       = line_addr[SET_ADDR_WIDTH-1:0];
    assign arr_wdata       = line_buf;
    assign refill_err      = sticky_err;

    // Refill FSM; every handshake/strobe output is a register updated together
    // with the state so each one is exactly a decode of the state it enters.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state            <= IDLE;
            line_addr        <= '0;
            beat_cnt         <= '0;
            // NOTE: the line buffer is reset too, because arr_wdata is a direct
            // view of it and must read zero while reset is asserted.
            line_buf         <= '0;
            sticky_err       <= 1'b0;
            refill_ready     <= 1'b1;
            refill_done      <= 1'b0;
            mem_rd_req_valid <= 1'b0;
            mem_rd_rsp_ready <= 1'b0;
            arr_wen          <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every right-hand
            // side below reads the value from before this clock edge.
            case (state)
                IDLE: begin
                    if (refill_valid) begin
                        line_addr        <= refill_addr[ADDR_WIDTH-1:OFFSET_WIDTH];
                        beat_cnt         <= '0;
                        sticky_err       <= 1'b0;
                        refill_ready     <= 1'b0;
                        mem_rd_req_valid <= 1'b1;
                        state            <= REQ;
                    end
                end

                REQ: begin
                    if (mem_rd_req_ready) begin
                        mem_rd_req_valid <= 1'b0;
                        mem_rd_rsp_ready <= 1'b1;
                        state            <= RECV;
                    end
                end

                RECV: begin
                    if (mem_rd_rsp_valid) begin
                        for (int i = 0; i < BEATS; i++) begin
                            if (beat_cnt == CNT_WIDTH'(i)) begin
                                line_buf[i*BEAT_WIDTH +: BEAT_WIDTH] <= mem_rd_rsp_data;
                            end
                        end
                        beat_cnt <= beat_cnt + 1'b1;

                        if (beat_cnt == CNT_WIDTH'(BEATS - 1)) begin
                            // Final beat: the line is written even when the
                            // memory forgot to mark it last.
                            mem_rd_rsp_ready <= 1'b0;
                            arr_wen          <= 1'b1;
                            refill_done      <= 1'b1;
                            sticky_err       <= ~mem_rd_rsp_last;
                            state            <= WRITE;
                        end else if (mem_rd_rsp_last) begin
                            // Early last: the line is incomplete, so finish
                            // through the write slot with the write suppressed.
                            mem_rd_rsp_ready <= 1'b0;
                            arr_wen          <= 1'b0;
                            refill_done      <= 1'b1;
                            sticky_err       <= 1'b1;
                            state            <= WRITE;
                        end
                    end
                end

                WRITE: begin
                    arr_wen      <= 1'b0;
                    refill_done  <= 1'b0;
                    sticky_err   <= 1'b0;
                    refill_ready <= 1'b1;
                    state        <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_refill_engine.sv
// Directed bench for cache_refill_engine: normal refill, stalled handshakes,
// early-last abort, missing last, mid-burst reset and back-to-back requests.
module tb_cache_refill_engine;

    logic         clk;
    logic         resetn;
    logic         refill_valid;
    logic [31:0]  refill_addr;
    logic         refill_ready;
    logic         refill_done;
    logic         refill_err;
    logic         mem_rd_req_valid;
    logic [31:0]  mem_rd_req_addr;
    logic [7:0]   mem_rd_req_len;
    logic         mem_rd_req_ready;
    logic         mem_rd_rsp_valid;
    logic [31:0]  mem_rd_rsp_data;
    logic         mem_rd_rsp_last;
    logic         mem_rd_rsp_ready;
    logic         arr_wen;
    logic [2:0]   arr_waddr;
    logic [255:0] arr_wdata;

    int checks = 0;
    int errors = 0;

    cache_refill_engine dut (
        .clk              (clk),
        .resetn           (resetn),
        .refill_valid     (refill_valid),
        .refill_addr      (refill_addr),
        .refill_ready     (refill_ready),
        .refill_done      (refill_done),
        .refill_err       (refill_err),
        .mem_rd_req_valid (mem_rd_req_valid),
        .mem_rd_req_addr  (mem_rd_req_addr),
        .mem_rd_req_len   (mem_rd_req_len),
        .mem_rd_req_ready (mem_rd_req_ready),
        .mem_rd_rsp_valid (mem_rd_rsp_valid),
        .mem_rd_rsp_data  (mem_rd_rsp_data),
        .mem_rd_rsp_last  (mem_rd_rsp_last),
        .mem_rd_rsp_ready (mem_rd_rsp_ready),
        .arr_wen          (arr_wen),
        .arr_waddr        (arr_waddr),
        .arr_wdata        (arr_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", tag, got, exp);
        end
    endtask

    // Runs one refill against a cycle-accurate memory model. Cycle 0 is the
    // cycle in which the request is presented; done_cycle is counted from it.
    task automatic do_refill(input string tag, input logic [31:0] addr,
                             input int req_stall, input logic [7:0] gap_mask,
                             input int last_at, input logic [31:0] dofs,
                             input logic [255:0] exp_line, input logic exp_write,
                             input logic exp_err, input int exp_done,
                             input logic hold, input logic [31:0] next_addr);
        int   cyc;
        int   k;
        int   rcv;
        int   done_cyc;
        int   req_cycles;
        logic req_ok;
        logic early_wen;
        logic fire;
        logic [31:0] exp_req_addr;

        exp_req_addr = {addr[31:5], 5'b0};
        check({tag, "_ready_at_start"}, 256'(refill_ready), 256'(1));
        refill_valid     = 1'b1;
        refill_addr      = addr;
        mem_rd_req_ready = 1'b0;
        mem_rd_rsp_valid = 1'b1;            // garbage beat outside RECV, must be ignored
        mem_rd_rsp_data  = 32'hDEAD_BEEF;
        mem_rd_rsp_last  = 1'b1;
        cyc = 0; k = 0; rcv = 0; done_cyc = -1; req_cycles = 0;
        req_ok = 1'b1; early_wen = 1'b0;

        while (done_cyc < 0 && cyc < 200) begin
            fire = mem_rd_rsp_valid && mem_rd_rsp_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (fire) k++;
            if (cyc == 1) begin
                refill_valid = hold;
                if (hold) refill_addr = next_addr;
            end

            if (mem_rd_req_valid) begin
                req_cycles++;
                if (mem_rd_req_addr !== exp_req_addr || mem_rd_req_len !== 8'd7) req_ok = 1'b0;
            end

            if (refill_done) begin
                done_cyc = cyc;
            end else begin
                if (arr_wen) early_wen = 1'b1;
                mem_rd_req_ready = (cyc >= 1 + req_stall);
                if (mem_rd_rsp_ready) begin
                    mem_rd_rsp_valid = (rcv < 8) ? !gap_mask[rcv[2:0]] : 1'b1;
                    mem_rd_rsp_data  = dofs + 32'h1111_1111 * (k + 1);
                    mem_rd_rsp_last  = (k == last_at);
                    rcv++;
                end else begin
                    mem_rd_rsp_valid = 1'b1;
                    mem_rd_rsp_data  = 32'hDEAD_BEEF;
                    mem_rd_rsp_last  = 1'b1;
                end
            end
        end

        mem_rd_req_ready = 1'b0;
        mem_rd_rsp_valid = 1'b0;
        mem_rd_rsp_last  = 1'b0;

        check({tag, "_done_cycle"}, 256'(done_cyc), 256'(exp_done));
        check({tag, "_req_stable"}, 256'(req_ok), 256'(1));
        check({tag, "_req_cycles"}, 256'(req_cycles), 256'(req_stall + 1));
        check({tag, "_no_early_wen"}, 256'(early_wen), 256'(0));
        check({tag, "_wen"}, 256'(arr_wen), 256'(exp_write));
        check({tag, "_err"}, 256'(refill_err), 256'(exp_err));
        if (exp_write) begin
            check({tag, "_waddr"}, 256'(arr_waddr), 256'(addr[7:5]));
            check({tag, "_wdata"}, arr_wdata, exp_line);
        end

        @(posedge clk);
        #1;
        check({tag, "_ready_after"}, 256'(refill_ready), 256'(1));
        check({tag, "_wen_after"}, 256'(arr_wen), 256'(0));
        check({tag, "_done_after"}, 256'(refill_done), 256'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 256'(refill_ready), 256'(1));
        check({tag, "_done"}, 256'(refill_done), 256'(0));
        check({tag, "_err"}, 256'(refill_err), 256'(0));
        check({tag, "_req_valid"}, 256'(mem_rd_req_valid), 256'(0));
        check({tag, "_req_addr"}, 256'(mem_rd_req_addr), 256'(0));
        check({tag, "_req_len"}, 256'(mem_rd_req_len), 256'(7));
        check({tag, "_rsp_ready"}, 256'(mem_rd_rsp_ready), 256'(0));
        check({tag, "_wen"}, 256'(arr_wen), 256'(0));
        check({tag, "_waddr"}, 256'(arr_waddr), 256'(0));
        check({tag, "_wdata"}, arr_wdata, 256'(0));
    endtask

    localparam logic [255:0] LINE_A =
        256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111;
    localparam logic [255:0] LINE_NOLAST =
        256'h88888988_77777877_66666766_55555655_44444544_33333433_22222322_11111211;
    localparam logic [255:0] LINE_B2B_1 =
        256'h8888888A_77777779_66666668_55555557_44444446_33333335_22222224_11111113;
    localparam logic [255:0] LINE_B2B_2 =
        256'h8888D888_7777C777_6666B666_5555A555_44449444_33338333_22227222_11116111;

    int   idle_wen;

    initial begin
        resetn           = 1'b0;
        refill_valid     = 1'b0;
        refill_addr      = '0;
        mem_rd_req_ready = 1'b0;
        mem_rd_rsp_valid = 1'b0;
        mem_rd_rsp_data  = '0;
        mem_rd_rsp_last  = 1'b0;

        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Nominal refill: line 0x1A0, set 5, write at cycle 10.
        do_refill("single", 32'h0000_01A4, 0, 8'b0000_0000, 7, 32'h0,
                  LINE_A, 1'b1, 1'b0, 10, 1'b0, 32'h0);

        // Request held off 3 cycles and 3 response gaps: done 6 cycles later.
        do_refill("stall", 32'h0000_01A4, 3, 8'b0010_0101, 7, 32'h0,
                  LINE_A, 1'b1, 1'b0, 16, 1'b0, 32'h0);

        // Last on beat 3 (accepted in cycle 5): abort pulse in cycle 6.
        do_refill("early_last", 32'h0000_0040, 0, 8'b0000_0000, 3, 32'h0,
                  256'h0, 1'b0, 1'b1, 6, 1'b0, 32'h0);

        // Last never asserted: line still written to set 7, error flagged.
        do_refill("no_last", 32'h0000_00E0, 0, 8'b0000_0000, -1, 32'h0000_0100,
                  LINE_NOLAST, 1'b1, 1'b1, 10, 1'b0, 32'h0);

        // Reset while beat 4 is on the bus.
        refill_valid = 1'b1;
        refill_addr  = 32'h0000_0160;
        @(posedge clk);
        #1;
        refill_valid     = 1'b0;
        mem_rd_req_ready = 1'b1;
        @(posedge clk);
        #1;
        mem_rd_req_ready = 1'b0;
        mem_rd_rsp_valid = 1'b1;
        mem_rd_rsp_data  = 32'hCAFE_0000;
        mem_rd_rsp_last  = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("midreset_busy", 256'(mem_rd_rsp_ready), 256'(1));
        #2;
        resetn = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        idle_wen = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (arr_wen || refill_done) idle_wen++;
        end
        check("midreset_no_write", 256'(idle_wen), 256'(0));
        mem_rd_rsp_valid = 1'b0;
        do_refill("after_reset", 32'h0000_01A4, 0, 8'b0000_0000, 7, 32'h0,
                  LINE_A, 1'b1, 1'b0, 10, 1'b0, 32'h0);

        // Back-to-back with refill_valid held: second accepted right after WRITE.
        do_refill("b2b_first", 32'h0000_0044, 0, 8'b0000_0000, 7, 32'h0000_0002,
                  LINE_B2B_1, 1'b1, 1'b0, 10, 1'b1, 32'h0000_03E8);
        check("b2b_valid_held", 256'(refill_valid), 256'(1));
        do_refill("b2b_second", 32'h0000_03E8, 0, 8'b0000_0000, 7, 32'h0000_5000,
                  LINE_B2B_2, 1'b1, 1'b0, 10, 1'b0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_refill_engine.md
# cache_refill_engine

Line-refill engine for the custom CPU cache. It accepts a refill request for one missed line and issues a single burst read to memory. It assembles the returned 32-bit beats into a 256-bit line, then writes the line into the cache data array in one write cycle. It sits between the cache control FSM (request side), the memory read channel, and the data array's write port (`wen`/`waddr`/`wdata`).

## Interface
Parameters:
- `LINE_WIDTH`, 256, cache line width in bits; must equal data-array data width
- `BEAT_WIDTH`, 32, memory read-response data width
- `SET_ADDR_WIDTH`, 3, data-array index width (8 sets)
- `ADDR_WIDTH`, 32, byte address width

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `refill_valid`  in  1  cache FSM requests a refill
- `refill_addr`  in  ADDR_WIDTH  byte address inside the missed line
- `refill_ready`  out  1  engine idle, request accepted this cycle if `refill_valid`
- `refill_done`  out  1  one-cycle pulse, refill finished (written or aborted)
- `refill_err`  out  1  one-cycle pulse with `refill_done` on a protocol error
- `mem_rd_req_valid`  out  1  burst read request valid
- `mem_rd_req_addr`  out  ADDR_WIDTH  line-aligned burst start address
- `mem_rd_req_len`  out  8  beats minus one, constant 7
- `mem_rd_req_ready`  in  1  memory accepts request
- `mem_rd_rsp_valid`  in  1  response beat valid
- `mem_rd_rsp_data`  in  BEAT_WIDTH  response beat data
- `mem_rd_rsp_last`  in  1  final beat of burst
- `mem_rd_rsp_ready`  out  1  engine accepts response beat
- `arr_wen`  out  1  data-array write enable
- `arr_waddr`  out  SET_ADDR_WIDTH  data-array set index
- `arr_wdata`  out  LINE_WIDTH  assembled line

## Operation
- States: IDLE, REQ, RECV, WRITE.
- `refill_ready` = (state == IDLE).
- IDLE, on `refill_valid`: latch `refill_addr`, clear beat counter, go to REQ.
- REQ: hold `mem_rd_req_valid` = 1 and `mem_rd_req_addr` = latched address with bits [4:0] forced to 0 until `mem_rd_req_ready`, then go to RECV.
- RECV: `mem_rd_rsp_ready` = 1. Each accepted beat k (3-bit counter, 0..7) is stored to line bits [32k+31:32k], then the counter increments.
- Beat 7 accepted: go to WRITE. If `mem_rd_rsp_last` was 0 on that beat, set a sticky error flag. The line is still written.
- `mem_rd_rsp_last` = 1 on a beat k < 7 (early last): abort. No array write, pulse `refill_done` and `refill_err` next cycle, return to IDLE.
- WRITE, exactly one cycle:
  - `arr_wen` = 1
  - `arr_waddr` = latched address bits [7:5]
  - `arr_wdata` = assembled buffer
  - `refill_done` = 1; `refill_err` = sticky error flag
  - Next state IDLE; sticky flag cleared.
- `arr_wen` is 0 in every state other than WRITE. `arr_wdata` and `arr_waddr` are don't-care while `arr_wen` = 0.
- `mem_rd_req_valid` and `mem_rd_rsp_ready` are 0 outside REQ and RECV respectively. Response beats outside RECV are not accepted.
- `refill_valid` while not IDLE is ignored. The requester must hold `refill_valid` until it sees `refill_ready`.
- `mem_rd_req_addr`, `mem_rd_req_len` and `arr_waddr` stay stable throughout a request.

## Timing
- Reset (`resetn` low, takes effect immediately):
  - State → IDLE; counter, sticky flag and buffer cleared.
  - `refill_ready` = 1; every other output 0 (`mem_rd_req_len` stays constant 7).
- Reset mid-operation abandons the refill with no array write and no `refill_done`. A burst the memory has already accepted is the memory side's responsibility.
- Minimum latency (memory ready every cycle):
  - Cycle 0: request accepted.
  - Cycle 1: REQ handshake.
  - Cycles 2–9: 8 beats.
  - Cycle 10: WRITE, with `arr_wen` and `refill_done`.
  - Cycle 11: `refill_ready` = 1; the new line is readable from the array combinationally.
- Response stalls (`mem_rd_rsp_valid` = 0) extend RECV without losing the counter or buffer.
- Early-last abort: `refill_done`/`refill_err` pulse in the cycle after the offending beat; IDLE follows.
- No back-to-back overlap: a new request is accepted no earlier than the cycle after WRITE.

## Test plan
- Single refill, `refill_addr` = 0x0000_01A4, memory always ready, beats 0x11111111..0x88888888 with last on beat 7. Required:
  - `mem_rd_req_addr` = 0x0000_01A0 and `mem_rd_req_len` = 7.
  - `arr_wen` at cycle 10, `arr_waddr` = 5, `arr_wdata` = {0x88888888,...,0x11111111}.
  - `refill_done` = 1 and `refill_err` = 0 at cycle 10.
- `mem_rd_req_ready` held low 3 cycles, random `mem_rd_rsp_valid` gaps. Required: `mem_rd_req_valid` and the request address stay stable; same line is written; `refill_done` is delayed exactly by the stall count.
- `mem_rd_rsp_last` asserted on beat 3. Required: no `arr_wen`; `refill_done` and `refill_err` pulse together; `refill_ready` = 1 the following cycle.
- 8 beats with `mem_rd_rsp_last` never asserted. Required: line written; `refill_err` = 1 with `refill_done`.
- `resetn` pulsed low during beat 4. Required: all outputs at reset values immediately, no `arr_wen`. A fresh refill afterwards completes correctly.
- Two requests, set indices 2 then 7, with `refill_valid` held high continuously. Required:
  - Second request accepted only in the cycle after the first WRITE.
  - Two separate `arr_wen` pulses with the correct data at `arr_waddr` 2 and then 7.
